// File: rtl/skew_stage_pkg.sv
// Shared constants and lane-depth helper for the skew stage.
// lane_delay() gives the register depth of one lane for a given geometry.
package skew_stage_pkg;

  localparam int MAX_LANES      = 16;
  localparam int MIN_LANES      = 2;
  localparam int MIN_BASE_DELAY = 1;

  function automatic int lane_delay(
    input int lane,
    input int lanes,
    input int base,
    input int dir
  );
    return (dir == 0) ? base + lane
                      : base + (lanes - 1 - lane);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the skew stage: enable/flush-capable shift line.
// Ports: i_clk, i_rst (async, high), i_en, i_flush, i_d -> o_q;
// o_next is the value the last stage loads on the next enabled edge.
module skew_delay_line
  import skew_stage_pkg::*;
#(
  parameter int P_WIDTH = 7,
  parameter int P_DEPTH = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_flush,
  input  logic [P_WIDTH-1:0] i_d,
  output logic [P_WIDTH-1:0] o_q,
  output logic [P_WIDTH-1:0] o_next
);

  logic [P_WIDTH-1:0] stage [P_DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < P_DEPTH; i++)
        stage[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < P_DEPTH; i++)
        stage[i] <= '0;
    end else if (i_en) begin
      stage[0] <= i_d;
      for (int i = 1; i < P_DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign o_q = stage[P_DEPTH-1];

  if (P_DEPTH == 1) begin : g_d1
    assign o_next = i_d;
  end else begin : g_dn
    assign o_next = stage[P_DEPTH-2];
  end

endmodule

// File: rtl/skew_stage.sv
// Lane skew stage: lane k delayed by lane_delay(k), valid tag per lane.
// Ports: i_clk, i_rst, i_en, i_valid, i_data, [i_flush] ->
// o_data, o_lane_vld, o_primed. i_flush exists with SKEW_STAGE_FLUSH_EN.
module skew_stage
  import skew_stage_pkg::*;
#(
  parameter int P_INPUT_WIDTH = 6,
  parameter int P_LANES       = 4,
  parameter int P_BASE_DELAY  = 1,
  parameter int P_DIR         = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic                             i_valid,
  input  logic [P_LANES*P_INPUT_WIDTH-1:0] i_data,
`ifdef SKEW_STAGE_FLUSH_EN
  input  logic                             i_flush,
`endif
  output logic [P_LANES*P_INPUT_WIDTH-1:0] o_data,
  output logic [P_LANES-1:0]               o_lane_vld,
  output logic                             o_primed
);

  localparam int W    = P_INPUT_WIDTH;
  localparam int LONG = (P_DIR == 0) ? P_LANES - 1 : 0;

  if (P_LANES < MIN_LANES || P_LANES > MAX_LANES) begin : g_bad_lanes
    $error("skew_stage: P_LANES out of range");
  end
  if (P_BASE_DELAY < MIN_BASE_DELAY) begin : g_bad_base
    $error("skew_stage: P_BASE_DELAY below minimum");
  end
  if (P_DIR != 0 && P_DIR != 1) begin : g_bad_dir
    $error("skew_stage: P_DIR must be 0 or 1");
  end
  if (P_INPUT_WIDTH < 1) begin : g_bad_width
    $error("skew_stage: P_INPUT_WIDTH must be positive");
  end

  logic flush;
`ifdef SKEW_STAGE_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  logic long_tag;
  logic primed_q;

  for (genvar k = 0; k < P_LANES; k++) begin : g_lane
    localparam int D =
      lane_delay(k, P_LANES, P_BASE_DELAY, P_DIR);
    // Only the longest lane's look-ahead tag is consumed.
    logic [W:0] nxt_unused;

    skew_delay_line #(
      .P_WIDTH (W + 1),
      .P_DEPTH (D)
    ) u_line (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_flush (flush),
      .i_d     ({i_valid, i_data[k*W +: W]}),
      .o_q     ({o_lane_vld[k], o_data[k*W +: W]}),
      .o_next  (nxt_unused)
    );

    if (k == LONG) begin : g_long
      assign long_tag = nxt_unused[W];
    end
  end

  // Look-ahead lets o_primed rise on the same edge the
  // longest lane's first valid tag reaches its output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      primed_q <= 1'b0;
    else if (flush)
      primed_q <= 1'b0;
    else if (i_en && long_tag)
      primed_q <= 1'b1;
  end

  assign o_primed = primed_q;

endmodule
